crc24_append: RTL

CRC24_APPEND -- requirements
Module: crc24_append

---
 rtl/btle_pkg.sv | 11 +
 rtl/crc24_step.sv | 14 +
 rtl/crc24_append.sv | 70 +++++++
 3 files changed

// File: rtl/btle_pkg.sv
// btle_pkg: constants and state type shared by the BLE CRC24 append blocks
package btle_pkg;
  localparam int          CRC_LEN           = 24;
  localparam logic [23:0] CRC_POLY          = 24'h00065B;
  localparam logic [23:0] BTLE_ADV_CRC_INIT = 24'h555555;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } crc_state_t;
endpackage

// File: rtl/crc24_step.sv
// crc24_step: one-bit Galois LFSR step of the BLE CRC24
module crc24_step
  import btle_pkg::*;
#(
  parameter int W = CRC_LEN
) (
  input  logic [W-1:0] crc_in,
  input  logic         bit_in,
  output logic [W-1:0] crc_out
);
  logic w_fb;
  assign w_fb    = crc_in[W-1] ^ bit_in;
  assign crc_out = {crc_in[W-2:0], 1'b0} ^ (w_fb ? W'(CRC_POLY) : '0);
endmodule

// File: rtl/crc24_append.sv
// crc24_append: passes PDU bits through and appends the 24-bit BLE CRC MSB-first
module crc24_append
  import btle_pkg::*;
#(
  parameter int CRC_STATE_INIT_BIT_WIDTH = CRC_LEN
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CRC_STATE_INIT_BIT_WIDTH-1:0] crc_init,
  input  logic                                crc_init_load,
  input  logic                                data_in,
  input  logic                                data_in_valid,
  input  logic                                data_in_last,
  output logic                                data_in_ready,
  output logic                                data_out,
  output logic                                data_out_valid,
  output logic                                crc_done
);
  localparam int W = CRC_STATE_INIT_BIT_WIDTH;
  crc_state_t   r_state;
  logic [W-1:0] r_crc;
  logic [4:0]   r_bit_cnt;
  logic [W-1:0] w_crc_next;
  logic         w_accept;
  assign data_in_ready = (r_state == ST_DATA);
  assign w_accept      = data_in_ready & data_in_valid;
  crc24_step #(.W(W)) u_step (
    .crc_in (r_crc),
    .bit_in (data_in),
    .crc_out(w_crc_next)
  );
  // A load restarts the packet from any state, which also aborts a CRC tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_crc          <= '0;
      r_bit_cnt      <= '0;
      data_out       <= 1'b0;
      data_out_valid <= 1'b0;
      crc_done       <= 1'b0;
    end else if (crc_init_load) begin
      r_state        <= ST_DATA;
      r_crc          <= crc_init;
      r_bit_cnt      <= '0;
      data_out_valid <= 1'b0;
      crc_done       <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      crc_done       <= 1'b0;
      if (w_accept) begin
        r_crc          <= w_crc_next;
        data_out       <= data_in;
        data_out_valid <= 1'b1;
        if (data_in_last) begin
          r_state   <= ST_CRC;
          r_bit_cnt <= '0;
        end
      end else if (r_state == ST_CRC) begin
        data_out       <= r_crc[W-1];
        r_crc          <= {r_crc[W-2:0], 1'b0};
        data_out_valid <= 1'b1;
        r_bit_cnt      <= r_bit_cnt + 5'd1;
        if (r_bit_cnt == 5'(CRC_LEN - 1)) begin
          crc_done <= 1'b1;
          r_state  <= ST_IDLE;
        end
      end
    end
  end
endmodule
